// File: rtl/sdram_ch_arbiter_if.sv
// Channel and memory-port bundle for sdram_ch_arbiter.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface sdram_ch_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 27,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_rnw;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_din;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH*DATA_W-1:0] ch_dout;
    logic [NUM_CH-1:0]        ch_err;

    logic                     mem_req;
    logic                     mem_rnw;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_din;
    logic                     mem_ready;
    logic                     mem_done;
    logic [DATA_W-1:0]        mem_dout;

    modport slave (
        input  ch_req, ch_rnw, ch_addr, ch_din, mem_ready, mem_done, mem_dout,
        output ch_ready, ch_done, ch_dout, ch_err, mem_req, mem_rnw, mem_addr, mem_din
    );

    modport master (
        output ch_req, ch_rnw, ch_addr, ch_din, mem_ready, mem_done, mem_dout,
        input  ch_ready, ch_done, ch_dout, ch_err, mem_req, mem_rnw, mem_addr, mem_din
    );
endinterface

// File: rtl/sdram_ch_arbiter.sv
// N-channel request front end for the single-port SDRAM controller.
// Optional watchdog abort of stuck transactions: define SDRAM_ARB_WATCHDOG_EN.
module sdram_ch_arbiter #(
    parameter int NUM_CH      = 3,
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 8,
    parameter int RR_MODE     = 1,
    parameter int WDOG_CYCLES = 1023
) (
    input logic               clk,
    input logic               reset,
    sdram_ch_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 2 || NUM_CH > 8 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("sdram_ch_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] req_rnw_q;
    logic [ADDR_W-1:0] req_addr_q [NUM_CH];
    logic [DATA_W-1:0] req_din_q  [NUM_CH];
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  winner;
    logic              win_valid;
    logic              wd_abort;

    // k-th channel in search order: rotated from ptr in round-robin, plain index otherwise.
    function automatic logic [IDX_W-1:0] ch_at(input logic [IDX_W-1:0] ptr, input int k);
        int s;
        s = (RR_MODE != 0) ? int'(ptr) + k : k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return IDX_W'(s);
    endfunction

    // Walk the order backwards so the earliest pending channel is the last assignment.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pend_q[ch_at(rr_ptr_q, k)]) begin
                winner    = ch_at(rr_ptr_q, k);
                win_valid = 1'b1;
            end
        end
    end

    assign bus.ch_ready = ~pend_q;

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0]   wd_cnt_q;
    logic [NUM_CH-1:0] err_q;
    assign wd_abort   = (state_q == StWait) && !bus.mem_done &&
                        (wd_cnt_q == WD_W'(WDOG_CYCLES - 1));
    assign bus.ch_err = err_q;
`else
    assign wd_abort   = 1'b0;
    assign bus.ch_err = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            req_rnw_q    <= '0;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_rnw  <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.ch_done  <= '0;
            bus.ch_dout  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                req_addr_q[i] <= '0;
                req_din_q[i]  <= '0;
            end
`ifdef SDRAM_ARB_WATCHDOG_EN
            wd_cnt_q <= '0;
            err_q    <= '0;
`endif
        end else begin
            bus.mem_req <= 1'b0;
            bus.ch_done <= '0;
`ifdef SDRAM_ARB_WATCHDOG_EN
            err_q <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.ch_req[i] && !pend_q[i]) begin
                    pend_q[i]     <= 1'b1;
                    req_rnw_q[i]  <= bus.ch_rnw[i];
                    req_addr_q[i] <= bus.ch_addr[i*ADDR_W +: ADDR_W];
                    req_din_q[i]  <= bus.ch_din[i*DATA_W +: DATA_W];
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (win_valid && bus.mem_ready) begin
                        grant_q      <= winner;
                        bus.mem_req  <= 1'b1;
                        bus.mem_rnw  <= req_rnw_q[winner];
                        bus.mem_addr <= req_addr_q[winner];
                        bus.mem_din  <= req_din_q[winner];
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
`ifdef SDRAM_ARB_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (bus.mem_done || wd_abort) begin
                        pend_q[grant_q]      <= 1'b0;
                        bus.ch_done[grant_q] <= 1'b1;
                        if (bus.mem_rnw) begin
                            bus.ch_dout[int'(grant_q)*DATA_W +: DATA_W] <=
                                wd_abort ? '1 : bus.mem_dout;
                        end
`ifdef SDRAM_ARB_WATCHDOG_EN
                        err_q[grant_q] <= wd_abort;
`endif
                        rr_ptr_q <= (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                        state_q  <= StIdle;
                    end
`ifdef SDRAM_ARB_WATCHDOG_EN
                    else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share channel stimulus,
// each with its own memory responder.
module tb_sdram_ch_arbiter;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 8;
    localparam int WDOG   = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sdram_ch_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) rr_if ();
    sdram_ch_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) fp_if ();

    sdram_ch_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(1), .WDOG_CYCLES(WDOG)
    ) u_rr (
        .clk(clk), .reset(reset), .bus(rr_if)
    );

    sdram_ch_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(0), .WDOG_CYCLES(WDOG)
    ) u_fp (
        .clk(clk), .reset(reset), .bus(fp_if)
    );

    logic              rr_done_r, fp_done_r, stray_done;
    logic [DATA_W-1:0] rr_dout_r, fp_dout_r;
    bit                rsp_on;
    logic [DATA_W-1:0] rsp_data;

    assign fp_if.ch_req    = rr_if.ch_req;
    assign fp_if.ch_rnw    = rr_if.ch_rnw;
    assign fp_if.ch_addr   = rr_if.ch_addr;
    assign fp_if.ch_din    = rr_if.ch_din;
    assign fp_if.mem_ready = rr_if.mem_ready;
    assign rr_if.mem_done  = rr_done_r | stray_done;
    assign fp_if.mem_done  = fp_done_r | stray_done;
    assign rr_if.mem_dout  = rr_dout_r;
    assign fp_if.mem_dout  = fp_dout_r;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responders: mem_done three cycles after the mem_req cycle.
    initial begin
        rr_done_r = 1'b0;
        rr_dout_r = '0;
        forever begin
            @(negedge clk);
            if (rr_if.mem_req === 1'b1 && rsp_on) begin
                repeat (3) @(posedge clk);
                #1 rr_done_r = 1'b1;
                rr_dout_r = rsp_data;
                @(posedge clk);
                #1 rr_done_r = 1'b0;
            end
        end
    end

    initial begin
        fp_done_r = 1'b0;
        fp_dout_r = '0;
        forever begin
            @(negedge clk);
            if (fp_if.mem_req === 1'b1 && rsp_on) begin
                repeat (3) @(posedge clk);
                #1 fp_done_r = 1'b1;
                fp_dout_r = rsp_data;
                @(posedge clk);
                #1 fp_done_r = 1'b0;
            end
        end
    end

    logic [ADDR_W-1:0] rr_addr_log[$];
    logic [ADDR_W-1:0] fp_addr_log[$];
    logic              rr_rnw_log[$];
    logic [DATA_W-1:0] rr_din_log[$];
    int                rr_req_cnt;
    int                rr_done_cnt[NUM_CH];

    initial begin
        forever begin
            @(negedge clk);
            if (rr_if.mem_req === 1'b1) begin
                rr_req_cnt++;
                rr_addr_log.push_back(rr_if.mem_addr);
                rr_rnw_log.push_back(rr_if.mem_rnw);
                rr_din_log.push_back(rr_if.mem_din);
            end
            if (fp_if.mem_req === 1'b1) fp_addr_log.push_back(fp_if.mem_addr);
            for (int i = 0; i < NUM_CH; i++) if (rr_if.ch_done[i] === 1'b1) rr_done_cnt[i]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL tb_timeout: got no finish expected finish");
        $fatal(1);
    end

    logic [ADDR_W-1:0] addr_v[NUM_CH];
    logic [DATA_W-1:0] din_v[NUM_CH];

    function automatic logic [ADDR_W-1:0] log_at(input logic [ADDR_W-1:0] q[$], input int k);
        return (k < q.size()) ? q[k] : '1;
    endfunction

    task automatic clear_logs();
        rr_addr_log.delete();
        fp_addr_log.delete();
        rr_rnw_log.delete();
        rr_din_log.delete();
        rr_req_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) rr_done_cnt[i] = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] rnw);
        rr_if.ch_req = mask;
        rr_if.ch_rnw = rnw;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_if.ch_addr[i*ADDR_W +: ADDR_W] = addr_v[i];
            rr_if.ch_din[i*DATA_W +: DATA_W]  = din_v[i];
        end
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] rnw);
        set_req(mask, rnw);
        next_cyc();
        rr_if.ch_req = '0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (rr_if.ch_ready == 3'b111 && fp_if.ch_ready == 3'b111) break;
        end
        check("idle_within_bound", (n < 400), 1'b1);
        next_cyc();
    endtask

    task automatic wait_done(input int ch, output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rr_if.ch_done[ch] === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_mem_req(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rr_if.mem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    int n;
    bit seen;

    initial begin
        rr_if.ch_req    = '0;
        rr_if.ch_rnw    = '0;
        rr_if.ch_addr   = '0;
        rr_if.ch_din    = '0;
        rr_if.mem_ready = 1'b1;
        stray_done      = 1'b0;
        rsp_on          = 1'b1;
        rsp_data        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            addr_v[i] = '0;
            din_v[i]  = '0;
        end
        clear_logs();

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", rr_if.ch_ready, 3'b111);
        check("rst_done", rr_if.ch_done, 3'b000);
        check("rst_err", rr_if.ch_err, 3'b000);
        check("rst_dout", rr_if.ch_dout, 24'h0);
        check("rst_mem_req", rr_if.mem_req, 1'b0);
        check("rst_mem_addr", rr_if.mem_addr, 27'h0);
        next_cyc();

        // Three rounds of simultaneous requests on all channels.
        rsp_data = 8'h10;
        for (int i = 0; i < NUM_CH; i++) addr_v[i] = 27'h100 + 27'(i);
        for (int r = 0; r < 3; r++) begin
            strobe(3'b111, 3'b111);
            wait_idle();
        end
        check("rr_grant_count", rr_addr_log.size(), 9);
        for (int k = 0; k < 9; k++) check("rr_grant_order", log_at(rr_addr_log, k), 27'h100 + 27'(k % 3));
        for (int r = 0; r < 3; r++) check("fp_ch0_first", log_at(fp_addr_log, 3 * r), 27'h100);

        // Single read on ch1 with cycle-exact latency.
        clear_logs();
        rsp_data  = 8'h5A;
        addr_v[1] = 27'h0001234;
        set_req(3'b010, 3'b010);
        next_cyc();
        rr_if.ch_req = '0;
        check("rd_ready_low", rr_if.ch_ready[1], 1'b0);
        @(negedge clk);
        check("rd_no_req_t1", rr_if.mem_req, 1'b0);
        next_cyc();
        @(negedge clk);
        check("rd_req_t2", rr_if.mem_req, 1'b1);
        check("rd_mem_addr", rr_if.mem_addr, 27'h0001234);
        check("rd_mem_rnw", rr_if.mem_rnw, 1'b1);
        wait_done(1, n);
        check("rd_done_lat", n, 4);
        check("rd_dout", rr_if.ch_dout[15:8], 8'h5A);
        check("rd_ready_back", rr_if.ch_ready[1], 1'b1);
        check("rd_err", rr_if.ch_err[1], 1'b0);
        wait_idle();

        // rr_ptr is 2 now: round-robin serves ch2 first, fixed priority ch1.
        clear_logs();
        rsp_data  = 8'h33;
        addr_v[1] = 27'h101;
        addr_v[2] = 27'h102;
        strobe(3'b110, 3'b110);
        wait_idle();
        check("rr_ptr_first", log_at(rr_addr_log, 0), 27'h102);
        check("rr_ptr_second", log_at(rr_addr_log, 1), 27'h101);
        check("fp_first", log_at(fp_addr_log, 0), 27'h101);
        check("fp_second", log_at(fp_addr_log, 1), 27'h102);

        // Write then read on ch2.
        clear_logs();
        rsp_data  = 8'h99;
        addr_v[2] = 27'h2222;
        din_v[2]  = 8'hC3;
        strobe(3'b100, 3'b000);
        wait_idle();
        check("wr_rnw", (rr_rnw_log.size() > 0) ? rr_rnw_log[0] : 1'bx, 1'b0);
        check("wr_din", (rr_din_log.size() > 0) ? rr_din_log[0] : 8'hxx, 8'hC3);
        check("wr_addr", log_at(rr_addr_log, 0), 27'h2222);
        check("wr_dout_kept", rr_if.ch_dout[23:16], 8'h33);
        rsp_data = 8'h77;
        strobe(3'b100, 3'b100);
        wait_idle();
        check("rd2_dout", rr_if.ch_dout[23:16], 8'h77);
        check("rd2_ch1_dout", rr_if.ch_dout[15:8], 8'h33);

        // Dropped second ch0 strobe; ch1 strobed in the ch0 mem_done cycle.
        clear_logs();
        rsp_data  = 8'h44;
        addr_v[0] = 27'h300;
        addr_v[1] = 27'h111;
        set_req(3'b001, 3'b001);
        next_cyc();
        set_req(3'b001, 3'b001);
        next_cyc();
        rr_if.ch_req = '0;
        @(negedge clk);
        check("sim_ch0_issue", rr_if.mem_req, 1'b1);
        next_cyc();
        next_cyc();
        next_cyc();
        set_req(3'b010, 3'b010);
        next_cyc();
        rr_if.ch_req = '0;
        @(negedge clk);
        check("sim_ch0_done", rr_if.ch_done[0], 1'b1);
        check("sim_no_req_d1", rr_if.mem_req, 1'b0);
        next_cyc();
        @(negedge clk);
        check("sim_ch1_req_d2", rr_if.mem_req, 1'b1);
        check("sim_ch1_addr", rr_if.mem_addr, 27'h111);
        wait_idle();
        check("sim_ch0_done_cnt", rr_done_cnt[0], 1);
        check("sim_ch1_done_cnt", rr_done_cnt[1], 1);
        check("sim_req_cnt", rr_req_cnt, 2);

        // mem_ready low holds requests; reset mid-WAIT abandons the transaction.
        clear_logs();
        rr_if.mem_ready = 1'b0;
        addr_v[0] = 27'h400;
        addr_v[2] = 27'h402;
        strobe(3'b101, 3'b101);
        repeat (20) next_cyc();
        check("hold_no_req", rr_req_cnt, 0);
        check("hold_pending", rr_if.ch_ready, 3'b010);
        rsp_on = 1'b0;
        rr_if.mem_ready = 1'b1;
        wait_mem_req(seen);
        check("hold_issue", seen, 1'b1);
        next_cyc();
        next_cyc();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", rr_if.ch_ready, 3'b111);
        check("mid_rst_mem_req", rr_if.mem_req, 1'b0);
        check("mid_rst_mem_addr", rr_if.mem_addr, 27'h0);
        check("mid_rst_dout", rr_if.ch_dout, 24'h0);
        next_cyc();
        reset = 1'b0;
        clear_logs();
        stray_done = 1'b1;
        next_cyc();
        stray_done = 1'b0;
        repeat (5) next_cyc();
        check("stray_no_done", rr_done_cnt[0] + rr_done_cnt[1] + rr_done_cnt[2], 0);
        check("stray_no_req", rr_req_cnt, 0);
        check("stray_ready", rr_if.ch_ready, 3'b111);

`ifdef SDRAM_ARB_WATCHDOG_EN
        // No mem_done at all: both transactions abort after the watchdog limit.
        clear_logs();
        addr_v[1] = 27'h501;
        addr_v[2] = 27'h502;
        strobe(3'b110, 3'b110);
        wait_mem_req(seen);
        check("wd_issue", seen, 1'b1);
        check("wd_first_addr", rr_if.mem_addr, 27'h501);
        wait_done(1, n);
        check("wd_done_lat", n, WDOG + 1);
        check("wd_err", rr_if.ch_err[1], 1'b1);
        check("wd_dout", rr_if.ch_dout[15:8], 8'hFF);
        wait_mem_req(seen);
        check("wd_next_issue", seen, 1'b1);
        check("wd_next_addr", rr_if.mem_addr, 27'h502);
        wait_idle();
        check("wd_ch2_dout", rr_if.ch_dout[23:16], 8'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_ch_arbiter.md
Name: sdram_ch_arbiter

Overview:
- Parametrised N-channel front end for the single-port SDRAM controller.
- Replaces the fixed ch1/ch2/ch3 hookup with one generic block: slot RAM, flash loader, and future DMA users each get their own request channel.
- Latches one request per channel, arbitrates in fixed-priority or round-robin order, and issues one transaction at a time on the memory port.
- Returns read data and a done strobe to the owning channel.

Parameters:
- NUM_CH, 3: number of request channels (2..8).
- ADDR_W, 27: address width.
- DATA_W, 8: data width.
- RR_MODE, 1: 1 = round-robin arbitration; 0 = fixed priority, channel 0 highest.
- WDOG_CYCLES, 1023: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ch_req  in  NUM_CH  per-channel request strobe, 1 cycle
- ch_rnw  in  NUM_CH  1 = read, 0 = write
- ch_addr  in  NUM_CH*ADDR_W  flattened; channel i in bits [i*ADDR_W +: ADDR_W]
- ch_din  in  NUM_CH*DATA_W  write data, flattened the same way
- ch_ready  out  NUM_CH  channel may strobe a request
- ch_done  out  NUM_CH  1-cycle completion pulse
- ch_dout  out  NUM_CH*DATA_W  last read data per channel
- ch_err  out  NUM_CH  completion was a watchdog abort; valid with ch_done
- mem_req  out  1  1-cycle issue strobe to the SDRAM controller
- mem_rnw  out  1  direction of the issued transaction
- mem_addr  out  ADDR_W  address of the issued transaction
- mem_din  out  DATA_W  write data of the issued transaction
- mem_ready  in  1  controller idle, can accept mem_req
- mem_done  in  1  controller completion pulse
- mem_dout  in  DATA_W  read data, valid with mem_done

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - All outputs clear to 0, except ch_ready, which goes all-1.
  - pend = 0, state = IDLE, rr_ptr = 0.
  - Any in-flight transaction is abandoned; mem_done arriving after reset is ignored.
- Capture:
  - ch_req[i] with ch_ready[i]=1 at edge T stores rnw/addr/din in a per-channel register.
  - pend[i]=1 and ch_ready[i]=0 from T+1.
  - ch_req[i] while ch_ready[i]=0 is ignored; there is no queue.
- FSM IDLE:
  - If any pend bit is set and mem_ready=1, register the winner g and go to ISSUE.
  - RR_MODE=1: search order starts at rr_ptr and wraps modulo NUM_CH.
  - RR_MODE=0: lowest pending index wins.
- FSM ISSUE:
  - mem_req=1 for exactly one cycle; next state is WAIT.
  - mem_addr/mem_din/mem_rnw come from channel g's register and stay stable until the cycle after mem_done.
- FSM WAIT:
  - On mem_done at cycle D, at D+1: ch_done[g]=1 for one cycle, pend[g]=0, ch_ready[g]=1, state = IDLE.
  - rr_ptr = (g+1) mod NUM_CH.
  - Reads only: ch_dout[g] <= mem_dout at D+1 and is held until the next read completion on that channel. Writes leave ch_dout unchanged.
- mem_done in IDLE or ISSUE is ignored; the controller never completes in the same cycle as mem_req.
- Latency, idle arbiter, mem_ready=1: strobe at T, mem_req at T+2. Back-to-back grant: next mem_req at D+2.
- Simultaneous events:
  - A request strobe on channel g during cycle D is ignored, because ch_ready[g]=0 then.
  - A request on another channel during D is captured and is eligible at D+1.
- While mem_ready=0 the FSM stays in IDLE; pending requests are retained.

Optional Feature:
- Macro: SDRAM_ARB_WATCHDOG_EN.
- With the macro defined:
  - A counter starts in ISSUE. If WAIT lasts WDOG_CYCLES cycles without mem_done, complete channel g as normal, but with ch_err[g]=1 and, for reads, ch_dout[g] set to all-1s.
  - Return to IDLE; a late mem_done is ignored.
- Without the macro: no counter; WAIT persists until mem_done; ch_err is tied to 0.

Test Plan:
- Single read on ch1, addr 0x0001234, mem_dout=0x5A, 3 cycles after issue -> mem_req at T+2 with mem_addr=0x0001234, mem_rnw=1; ch_done[1] and ch_dout[1]=0x5A one cycle after mem_done; ch_ready[1] back to 1.
- RR_MODE=1, ch0/ch1/ch2 strobed in the same cycle, repeated 3 times -> grant order 0,1,2,0,1,2,0,1,2. RR_MODE=0 with the same stimulus -> ch0 completes first each round.
- Write on ch2, din=0xC3, followed by a read on ch2 -> mem_rnw=0 with mem_din=0xC3; ch_dout[2] unchanged by the write and updated only by the read.
- Second ch0 strobe while ch_ready[0]=0; ch1 strobe in the same cycle as ch0 mem_done -> extra ch0 strobe dropped (exactly one ch_done[0]); ch1 mem_req at D+2.
- mem_ready held 0 for 20 cycles with 2 channels pending, and reset asserted mid-WAIT -> no mem_req while mem_ready=0. After reset, outputs match reset values and a stray mem_done yields no ch_done.
- With SDRAM_ARB_WATCHDOG_EN and WDOG_CYCLES=16, mem_done never asserted -> ch_done[g]=1, ch_err[g]=1, ch_dout[g]=0xFF; the next pending channel is then issued.
